// File: rtl/uart_boot_loader_pkg.sv
// Shared types and byte constants for the UART boot loader.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LEN0,
        ST_LEN1,
        ST_DLO,
        ST_DHI,
        ST_CSUM,
        ST_REPLY,
        ST_RUN
    } boot_state_t;

    localparam logic [7:0] CMD_LOAD = 8'h55;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

endpackage

// File: rtl/uart_boot_loader.sv
// Boot sequencer: holds the J1 in reset, optionally downloads an image over the
// UART into RAM port A, then hands the UART and RAM port back to the CPU.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned BOOT_WAIT    = 200000000,
    parameter int unsigned BYTE_TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        boot_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        rx_rd,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    input  logic        cpu_uart_rd,
    input  logic        cpu_uart_wr,
    input  logic [7:0]  cpu_tx_data,
    input  logic [15:0] cpu_mem_addr,
    input  logic        cpu_mem_wr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_d,
    output logic        ram_wr,
    output logic        cpu_resetq,
    output logic        loading,
    output boot_state_t state_dbg
);

    // Handshakes: a byte is taken on any edge where rx_valid is high and rx_rd
    // was not high in the cycle before; rx_rd is then high for exactly the next
    // cycle. tx_wr is a one-cycle strobe issued only after tx_busy was seen low.
    boot_state_t state, state_next;

    logic        load_state, take, wait_hit, idle_hit, last_word, index_over;
    logic [31:0] wait_cnt, idle_cnt;
    logic [16:0] index;
    logic [15:0] len;
    logic [7:0]  lo_byte, sum;
    logic        overflow, ck_ok, reply_sent;
    logic        rx_rd_q, tx_wr_q, ram_wr_q, cpu_resetq_q;
    logic [7:0]  tx_data_q;
    logic [15:0] ram_addr_q, ram_d_q;

    assign load_state = (state inside {ST_LEN0, ST_LEN1, ST_DLO, ST_DHI, ST_CSUM});
    assign take       = (load_state || state == ST_WAIT) && rx_valid && !rx_rd_q;
    assign wait_hit   = wait_cnt >= 32'(BOOT_WAIT - 1);
    assign idle_hit   = idle_cnt >= 32'(BYTE_TIMEOUT - 1);
    assign last_word  = (index + 17'd1) == {1'b0, len};
    assign index_over = |index[16:ADDR_W];

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:  if (take && rx_data == CMD_LOAD) state_next = ST_LEN0;
                      else if (!take && wait_hit)      state_next = ST_RUN;
            ST_LEN0:  if (take)          state_next = ST_LEN1;
                      else if (idle_hit) state_next = ST_WAIT;
            ST_LEN1:  if (take)          state_next = ({rx_data, len[7:0]} == 16'd0) ? ST_CSUM : ST_DLO;
                      else if (idle_hit) state_next = ST_WAIT;
            ST_DLO:   if (take)          state_next = ST_DHI;
                      else if (idle_hit) state_next = ST_WAIT;
            ST_DHI:   if (take)          state_next = last_word ? ST_CSUM : ST_DLO;
                      else if (idle_hit) state_next = ST_WAIT;
            ST_CSUM:  if (take)          state_next = ST_REPLY;
                      else if (idle_hit) state_next = ST_WAIT;
            // Leave REPLY only after the strobe cycle, so tx_wr is never lost to the CPU mux.
            ST_REPLY: if (reply_sent)    state_next = ck_ok ? ST_RUN : ST_WAIT;
            ST_RUN:   if (boot_req)      state_next = ST_WAIT;
            default:                     state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state        <= ST_WAIT;
            wait_cnt     <= '0;
            idle_cnt     <= '0;
            index        <= '0;
            len          <= '0;
            lo_byte      <= '0;
            sum          <= '0;
            overflow     <= 1'b0;
            ck_ok        <= 1'b0;
            reply_sent   <= 1'b0;
            rx_rd_q      <= 1'b0;
            tx_wr_q      <= 1'b0;
            ram_wr_q     <= 1'b0;
            cpu_resetq_q <= 1'b0;
            tx_data_q    <= '0;
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
        end else begin
            state        <= state_next;
            rx_rd_q      <= take;
            ram_wr_q     <= 1'b0;
            tx_wr_q      <= 1'b0;
            cpu_resetq_q <= (state_next == ST_RUN);

            // Every fresh entry into WAIT opens a full boot window.
            if (state == ST_WAIT)           wait_cnt <= wait_cnt + 32'd1;
            else if (state_next == ST_WAIT) wait_cnt <= '0;

            if (load_state && !take) idle_cnt <= idle_cnt + 32'd1;
            else                     idle_cnt <= '0;

            case (state)
                ST_WAIT: if (take && rx_data == CMD_LOAD) begin
                    index    <= '0;
                    sum      <= '0;
                    overflow <= 1'b0;
                end
                ST_LEN0: if (take) len[7:0]  <= rx_data;
                ST_LEN1: if (take) len[15:8] <= rx_data;
                ST_DLO: if (take) begin
                    lo_byte <= rx_data;
                    sum     <= sum + rx_data;
                end
                ST_DHI: if (take) begin
                    sum        <= sum + rx_data;
                    ram_wr_q   <= !index_over;
                    ram_addr_q <= {{(16 - ADDR_W){1'b0}}, index[ADDR_W-1:0]};
                    ram_d_q    <= {rx_data, lo_byte};
                    overflow   <= overflow | index_over;
                    index      <= index + 17'd1;
                end
                ST_CSUM: if (take) begin
                    ck_ok      <= (rx_data == sum) && !overflow;
                    reply_sent <= 1'b0;
                end
                ST_REPLY: if (!reply_sent && !tx_busy) begin
                    tx_wr_q    <= 1'b1;
                    tx_data_q  <= ck_ok ? ACK : NAK;
                    reply_sent <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (state == ST_RUN) begin
            rx_rd    = cpu_uart_rd;
            tx_wr    = cpu_uart_wr;
            tx_data  = cpu_tx_data;
            ram_addr = cpu_mem_addr;
            ram_d    = cpu_dout;
            ram_wr   = cpu_mem_wr;
        end else begin
            rx_rd    = rx_rd_q;
            tx_wr    = tx_wr_q;
            tx_data  = tx_data_q;
            ram_addr = ram_addr_q;
            ram_d    = ram_d_q;
            ram_wr   = ram_wr_q;
        end
    end

    assign cpu_resetq = cpu_resetq_q;
    assign loading    = (state != ST_RUN);
    assign state_dbg  = state;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed-random bench for uart_boot_loader: frames are built from a word list,
// and expected RAM writes / reply byte come from the load protocol rules.
module tb_uart_boot_loader;
    import uart_boot_loader_pkg::*;

    localparam int ADDR_W       = 9;
    localparam int BOOT_WAIT    = 100;
    localparam int BYTE_TIMEOUT = 50;
    localparam int DEPTH        = 1 << ADDR_W;

    logic        clk = 1'b0, resetq = 1'b0, boot_req = 1'b0;
    logic        rx_valid = 1'b0, tx_busy = 1'b0;
    logic [7:0]  rx_data = '0, cpu_tx_data = '0;
    logic        cpu_uart_rd = 1'b0, cpu_uart_wr = 1'b0, cpu_mem_wr = 1'b0;
    logic [15:0] cpu_mem_addr = '0, cpu_dout = '0;
    logic        rx_rd, tx_wr, ram_wr, cpu_resetq, loading;
    logic [7:0]  tx_data;
    logic [15:0] ram_addr, ram_d;
    boot_state_t state_dbg;

    int          checks = 0, failures = 0, cyc = 0, last_rx_cyc = 0;
    logic [31:0] wr_q[$], exp_q[$];
    logic [7:0]  tx_q[$], frame_q[$];
    int          tx_cyc_q[$];
    logic [15:0] words_q[$];
    logic [7:0]  exp_reply;

    uart_boot_loader #(.ADDR_W(ADDR_W), .BOOT_WAIT(BOOT_WAIT), .BYTE_TIMEOUT(BYTE_TIMEOUT)) dut (
        .clk(clk), .resetq(resetq), .boot_req(boot_req),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
        .rx_rd(rx_rd), .tx_wr(tx_wr), .tx_data(tx_data),
        .cpu_uart_rd(cpu_uart_rd), .cpu_uart_wr(cpu_uart_wr), .cpu_tx_data(cpu_tx_data),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wr(cpu_mem_wr), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_wr(ram_wr),
        .cpu_resetq(cpu_resetq), .loading(loading), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // monitor: loader-owned RAM writes and UART transmits
    always @(negedge clk) begin
        if (resetq && loading) begin
            if (ram_wr) wr_q.push_back({ram_addr, ram_d});
            if (tx_wr) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        resetq = 1'b0; rx_valid = 1'b0; tx_busy = 1'b0; boot_req = 1'b0;
        cpu_uart_rd = 1'b0; cpu_uart_wr = 1'b0; cpu_mem_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cpu_resetq", 32'(cpu_resetq), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_rx_rd", 32'(rx_rd), 32'd0);
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_loading", 32'(loading), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(ST_WAIT));
        resetq = 1'b1;
        wr_q = {}; tx_q = {}; tx_cyc_q = {};
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_valid = 1'b1; rx_data = b; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_rd && n < 20);
        check("rx_rd_seen", 32'(rx_rd), 32'd1);
        rx_valid = 1'b0;
        last_rx_cyc = cyc;
    endtask

    task automatic send_frame(input int skip_last);
        for (int i = 0; i < frame_q.size() - skip_last; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send_byte(frame_q[i]);
        end
    endtask

    // reference model: frame bytes, expected writes and reply from the word list
    task automatic make_frame(input int bad_ck);
        logic [7:0] s;
        int n;
        n = words_q.size();
        s = '0;
        frame_q = {}; exp_q = {};
        frame_q.push_back(CMD_LOAD);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        foreach (words_q[i]) begin
            frame_q.push_back(words_q[i][7:0]);
            frame_q.push_back(words_q[i][15:8]);
            s = 8'(s + words_q[i][7:0] + words_q[i][15:8]);
            if (i < DEPTH) exp_q.push_back({16'(i), words_q[i]});
        end
        frame_q.push_back((bad_ck != 0) ? 8'(s + 8'd1) : s);
        exp_reply = (bad_ck == 0 && n <= DEPTH) ? ACK : NAK;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) if (i < wr_q.size()) check({tag, "_wr_word"}, wr_q[i], exp_q[i]);
    endtask

    task automatic wait_tx(input int limit);
        int n = 0;
        while (tx_q.size() == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("tx_seen", 32'(tx_q.size()), 32'd1);
    endtask

    task automatic wait_run(input int limit, output int c);
        int n = 0;
        while (!cpu_resetq && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("run_reached", 32'(cpu_resetq), 32'd1);
        c = cyc;
    endtask

    initial begin
        int rel, rise, ck_cyc, n;

        // 1: idle boot window expires
        do_reset();
        rel = cyc;
        wait_run(1000, rise);
        check("t1_window", 32'(rise - rel), 32'(BOOT_WAIT));
        check("t1_loading", 32'(loading), 32'd0);
        check("t1_no_ram_wr", 32'(wr_q.size()), 32'd0);
        check("t1_no_tx_wr", 32'(tx_q.size()), 32'd0);

        // 2: good two-word frame, reply held off by tx_busy
        do_reset();
        words_q = '{16'h1234, 16'hABCD};
        make_frame(0);
        send_frame(1);
        tx_busy = 1'b1;
        send_byte(frame_q[frame_q.size() - 1]);
        ck_cyc = last_rx_cyc;
        repeat (10) @(negedge clk);
        check("t2_no_tx_while_busy", 32'(tx_q.size()), 32'd0);
        tx_busy = 1'b0;
        wait_tx(50);
        wait_run(50, rise);
        check("t2_reply", 32'(tx_q[0]), 32'(exp_reply));
        check("t2_tx_delay", 32'(tx_cyc_q[0] - ck_cyc), 32'd11);
        check("t2_run_after_tx", 32'(rise - tx_cyc_q[0]), 32'd1);
        check_writes("t2");

        // 3: junk byte in WAIT, then bad checksum -> NAK and a fresh window
        do_reset();
        send_byte(8'h00);
        make_frame(1);
        send_frame(0);
        wait_tx(50);
        check("t3_reply", 32'(tx_q[0]), 32'(exp_reply));
        check("t3_tx_delay", 32'(tx_cyc_q[0] - last_rx_cyc), 32'd1);
        check_writes("t3");
        wait_run(500, rise);
        check("t3_rewait", 32'(rise - tx_cyc_q[0]), 32'(1 + BOOT_WAIT));

        // 4: one word past the end of RAM
        do_reset();
        words_q = {};
        for (int i = 0; i < DEPTH + 1; i++) words_q.push_back(16'($urandom));
        make_frame(0);
        send_frame(0);
        wait_tx(50);
        check("t4_reply", 32'(tx_q[0]), 32'(exp_reply));
        check_writes("t4");

        // 5: stalled load times out, then a random frame still loads
        do_reset();
        send_byte(CMD_LOAD); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34);
        ck_cyc = last_rx_cyc;
        n = 0;
        while (state_dbg != ST_WAIT && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout", 32'(cyc - ck_cyc), 32'(BYTE_TIMEOUT));
        repeat (10) @(negedge clk);
        check("t5_no_ram_wr", 32'(wr_q.size()), 32'd0);
        check("t5_no_tx_wr", 32'(tx_q.size()), 32'd0);
        check("t5_cpu_held", 32'(cpu_resetq), 32'd0);
        words_q = {};
        for (int i = 0; i < 3; i++) words_q.push_back(16'($urandom));
        make_frame(0);
        send_frame(0);
        wait_tx(50);
        wait_run(50, rise);
        check("t5_reply", 32'(tx_q[0]), 32'(exp_reply));
        check_writes("t5");

        // 6: CPU pass-through in RUN, then boot_req
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_mem_wr   = (i == 0) ? 1'b1 : 1'($urandom);
            cpu_mem_addr = (i == 0) ? 16'd5 : 16'($urandom);
            cpu_dout     = (i == 0) ? 16'hBEEF : 16'($urandom);
            cpu_uart_wr  = (i == 0) ? 1'b1 : 1'($urandom);
            cpu_uart_rd  = 1'($urandom);
            cpu_tx_data  = 8'($urandom);
            #1;
            check("t6_ram_wr", 32'(ram_wr), 32'(cpu_mem_wr));
            check("t6_ram_addr", 32'(ram_addr), 32'(cpu_mem_addr));
            check("t6_ram_d", 32'(ram_d), 32'(cpu_dout));
            check("t6_tx_wr", 32'(tx_wr), 32'(cpu_uart_wr));
            check("t6_tx_data", 32'(tx_data), 32'(cpu_tx_data));
            check("t6_rx_rd", 32'(rx_rd), 32'(cpu_uart_rd));
        end
        @(negedge clk);
        cpu_mem_wr = 1'b0; cpu_uart_wr = 1'b0; cpu_uart_rd = 1'b0;
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        rel = cyc;
        check("t6_boot_cpu_resetq", 32'(cpu_resetq), 32'd0);
        check("t6_boot_loading", 32'(loading), 32'd1);
        cpu_mem_wr = 1'b1; cpu_uart_wr = 1'b1;
        #1;
        check("t6_cpu_ignored_ram", 32'(ram_wr), 32'd0);
        check("t6_cpu_ignored_tx", 32'(tx_wr), 32'd0);
        cpu_mem_wr = 1'b0; cpu_uart_wr = 1'b0;
        @(negedge clk);
        wait_run(500, rise);
        check("t6_rewait", 32'(rise - rel), 32'(BOOT_WAIT));

        // 7: reset in the middle of a load returns to WAIT
        do_reset();
        send_byte(CMD_LOAD); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (2) @(negedge clk);
        check("t7_partial_write", 32'(wr_q.size()), 32'd1);
        do_reset();
        @(negedge clk);
        check("t7_cpu_held", 32'(cpu_resetq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
